mfp_ahb_rojo_updctrl: RTL
=========================

// Module: mfp_ahb_rojo_updctrl
// PURPOSE
//  Sequences the Rojobot update/interrupt handshake between the bot and the MIPSfpga core.
//  Edge-detects the bot's update strobe and snapshots BOTINFO so software always reads a coherent value.
//  Raises an interrupt request and holds it until software acknowledges through the INTACK MMIO bit.
//  Queues one update that arrives while an earlier one is unacknowledged, counts any further lost updates, and flags acks that take too long.
// PARAMETERS
//  TIMEOUT_CYC  1000000  cycles in PEND without an ack before TIMEOUT sets; 0 disables the timeout
//  MISS_W       8        width of the saturating missed-update counter
// PORTS
//  HCLK          in   1       system clock; single clock domain
//  HRESET        in   1       synchronous, active-high reset
//  BOT_UPDT      in   1       update level from rojobot, same clock domain; each rising edge is one update
//  BOT_INFO      in   32      live BOTINFO word from rojobot
//  INTACK        in   1       PORT_INTACK register bit written by software
//  PORT_BOTINFO  out  32      BOTINFO snapshot presented to the MMIO read mux
//  PORT_BOTUPDT  out  1       update-pending flag presented to the MMIO read mux
//  IRQ           out  1       interrupt request to the core's interrupt input
//  TIMEOUT       out  1       sticky flag: an ack was not seen within TIMEOUT_CYC cycles
//  MISS_CNT      out  MISS_W  saturating count of dropped updates
// BEHAVIOUR
//  Reset, on any HCLK edge with HRESET=1:
//   - every output is 0; state=IDLE; pending=0; shadow=0; edge-detect registers=0
//   - reset overrides all other events, including mid-handshake.
//  Edge detection:
//   - upd_e = BOT_UPDT & ~BOT_UPDT_q
//   - ack_e = INTACK & ~INTACK_q
//   - both BOT_UPDT_q and INTACK_q reset to 0.
//  States: IDLE, PEND, RELEASE.
//  IDLE:
//   - on upd_e, in the next cycle: PORT_BOTINFO<=BOT_INFO, PORT_BOTUPDT<=1, IRQ<=1, tmo_cnt<=0, state<=PEND
//   - latency from upd_e cycle to IRQ=1 is 1 clock.
//  PEND:
//   - tmo_cnt increments every cycle.
//   - When tmo_cnt==TIMEOUT_CYC-1 and TIMEOUT_CYC!=0: TIMEOUT<=1, sticky until reset. IRQ stays high and the state stays PEND.
//   - On ack_e: PORT_BOTUPDT<=0, IRQ<=0, state<=RELEASE. PORT_BOTINFO keeps its value.
//  RELEASE (waits for software to clear INTACK):
//   - While INTACK=1, stay in RELEASE.
//   - When INTACK=0 and pending=0: state<=IDLE.
//   - When INTACK=0 and pending=1: PORT_BOTINFO<=shadow, PORT_BOTUPDT<=1, IRQ<=1, pending<=0, tmo_cnt<=0, state<=PEND.
//  upd_e in PEND or RELEASE:
//   - If pending=0: shadow<=BOT_INFO, pending<=1.
//   - If pending=1: shadow<=BOT_INFO (newest value wins) and MISS_CNT increments, saturating at all-ones.
//   - PORT_BOTINFO is never overwritten while in PEND.
//  Simultaneous events:
//   - upd_e together with ack_e in PEND: the ack is processed and the update goes to pending. No miss, provided pending was 0.
//   - upd_e in the same RELEASE cycle that re-arms from pending: shadow<=BOT_INFO, pending stays 1, no miss.
//   - ack_e in IDLE or RELEASE is ignored.
//  MISS_CNT never wraps. TIMEOUT and MISS_CNT are cleared only by HRESET.
// TESTING
//  1. Basic handshake: BOT_INFO=32'h1234_5678, pulse BOT_UPDT. Next cycle: IRQ=1, PORT_BOTUPDT=1, PORT_BOTINFO=32'h1234_5678.
//  2. Ack sequence: INTACK=1 gives IRQ=0 one cycle later. INTACK=0 returns to IDLE. MISS_CNT=0, TIMEOUT=0.
//  3. Queued and lost updates: while in PEND, send updates with info A, then B, then C.
//     - After ack and INTACK release: IRQ=1 again and PORT_BOTINFO=C.
//     - MISS_CNT=2.
//  4. Timeout: TIMEOUT_CYC=16, update with no ack. TIMEOUT=1 exactly 16 cycles after IRQ rises, and IRQ stays 1. A later ack still completes the handshake.
//  5. Simultaneous events: BOT_UPDT edge and INTACK edge in the same PEND cycle. IRQ drops, then re-asserts after INTACK=0. MISS_CNT is unchanged.
//  6. Reset mid-handshake: assert HRESET for 1 cycle while in PEND with MISS_CNT=3. All outputs read 0 on the next cycle, and a fresh update works normally.

Source files
------------

// File: rtl/mfp_ahb_rojo_updctrl.sv
// Rojobot update/interrupt handshake: snapshots BOTINFO on each bot update, raises IRQ
// until software acks via INTACK, queues one overlapping update and counts dropped ones.
module mfp_ahb_rojo_updctrl #(
  parameter int unsigned TIMEOUT_CYC = 1000000,
  parameter int unsigned MISS_W      = 8
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic              BOT_UPDT,
  input  logic [31:0]       BOT_INFO,
  input  logic              INTACK,
  output logic [31:0]       PORT_BOTINFO,
  output logic              PORT_BOTUPDT,
  output logic              IRQ,
  output logic              TIMEOUT,
  output logic [MISS_W-1:0] MISS_CNT
);

  localparam int unsigned TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PEND    = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t            state, state_n;
  logic              bot_updt_q, intack_q;
  logic              pending, pending_n;
  logic [31:0]       shadow, shadow_n;
  logic [TMO_W-1:0]  tmo_cnt, tmo_n;
  logic [31:0]       info_n;
  logic              updt_n, irq_n, timeout_n;
  logic [MISS_W-1:0] miss_n;
  logic              upd_e, ack_e, rearm;

  assign upd_e = BOT_UPDT & ~bot_updt_q;
  assign ack_e = INTACK & ~intack_q;
  assign rearm = (state == RELEASE) && !INTACK && pending;

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state        <= IDLE;
      bot_updt_q   <= 1'b0;
      intack_q     <= 1'b0;
      pending      <= 1'b0;
      shadow       <= '0;
      tmo_cnt      <= '0;
      PORT_BOTINFO <= '0;
      PORT_BOTUPDT <= 1'b0;
      IRQ          <= 1'b0;
      TIMEOUT      <= 1'b0;
      MISS_CNT     <= '0;
    end else begin
      state        <= state_n;
      bot_updt_q   <= BOT_UPDT;
      intack_q     <= INTACK;
      pending      <= pending_n;
      shadow       <= shadow_n;
      tmo_cnt      <= tmo_n;
      PORT_BOTINFO <= info_n;
      PORT_BOTUPDT <= updt_n;
      IRQ          <= irq_n;
      TIMEOUT      <= timeout_n;
      MISS_CNT     <= miss_n;
    end
  end

  always_comb begin
    state_n   = state;
    pending_n = pending;
    shadow_n  = shadow;
    tmo_n     = tmo_cnt;
    info_n    = PORT_BOTINFO;
    updt_n    = PORT_BOTUPDT;
    irq_n     = IRQ;
    timeout_n = TIMEOUT;
    miss_n    = MISS_CNT;

    unique case (state)
      IDLE: begin
        if (upd_e) begin
          info_n  = BOT_INFO;
          updt_n  = 1'b1;
          irq_n   = 1'b1;
          tmo_n   = '0;
          state_n = PEND;
        end
      end
      PEND: begin
        tmo_n = tmo_cnt + TMO_W'(1);
        if ((TIMEOUT_CYC != 0) && (tmo_cnt == TMO_LAST))
          timeout_n = 1'b1;
        if (ack_e) begin
          updt_n  = 1'b0;
          irq_n   = 1'b0;
          state_n = RELEASE;
        end
      end
      RELEASE: begin
        if (!INTACK) begin
          if (pending) begin
            info_n    = shadow;
            updt_n    = 1'b1;
            irq_n     = 1'b1;
            pending_n = 1'b0;
            tmo_n     = '0;
            state_n   = PEND;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase

    // The shadow slot is drained on a re-arm cycle, so an update there refills it without a miss
    if (upd_e && (state != IDLE)) begin
      shadow_n  = BOT_INFO;
      pending_n = 1'b1;
      if (pending && !rearm && (MISS_CNT != '1))
        miss_n = MISS_CNT + MISS_W'(1);
    end
  end

endmodule
